mem_stage_access_unit: RTL and testbench
========================================

Name: mem_stage_access_unit

Overview:
- Consumer end of the EX/MEM pipeline register; it is the MEM stage of the pipelined CPU.
- Takes the registered EX/MEM fields and performs the data-RAM access through a req/ready handshake with variable latency.
- Holds the front of the pipeline via stall while the access is outstanding.
- Produces the registered MEM/WB writeback bundle and the resolved next-PC redirect.

Parameters:
- ADDR_WIDTH, 32, width of mem_addr (low bits of in_alu_rd_result).
- TIMEOUT_CYCLES, 255, max wait cycles for mem_ready before the access is abandoned (≥1).
- CNT_WIDTH, 8, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_pc_data  in  32  PC of the instruction in MEM.
- in_rd_address  in  5  destination register.
- in_alu_rd_result  in  32  ALU result / memory address.
- in_alu_rd_result_is_zero  in  1  branch condition.
- in_alu_pc_result  in  32  branch/jump target.
- in_next_pc_src  in  2  0=pc+4, 1=branch-if-zero, 2=jump to alu_pc_result, 3=jump to alu_rd_result.
- in_reg_write_data_src  in  1  0=ALU result, 1=load data.
- in_reg_wren  in  1  register write enable.
- in_ram_wren  in  1  store enable.
- in_store_data  in  32  store data.
- mem_req  out  1  access request, held until accepted.
- mem_we  out  1  1=write.
- mem_addr  out  ADDR_WIDTH  access address.
- mem_wdata  out  32  write data.
- mem_ready  in  1  completion; read data valid in same cycle.
- mem_rdata  in  32  load data.
- stall  out  1  1=hold IF/ID/EX and EX/MEM (drives their wren low).
- redirect  out  1  1=PC must load redirect_pc.
- redirect_pc  out  32  resolved next PC.
- wb_rd_address  out  5  MEM/WB destination.
- wb_data  out  32  MEM/WB write data.
- wb_reg_wren  out  1  MEM/WB write enable.
- mem_error  out  1  sticky timeout flag.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0. All registered outputs 0: mem_req, mem_we, mem_addr, mem_wdata, wb_*, mem_error. stall=0, redirect=0.
- Access classification: is_load = in_reg_write_data_src & ~in_ram_wren; is_store = in_ram_wren. in_ram_wren has priority if both are set; the instruction is then a store with wb_reg_wren=0.
- FSM states: IDLE, ACCESS, FINISH.
- IDLE with no access: single-cycle pass-through. Next edge: wb_rd_address=in_rd_address, wb_data=in_alu_rd_result, wb_reg_wren=in_reg_wren. stall=0.
- IDLE with a load or store: combinational stall=1 in the same cycle. Next edge: state→ACCESS, mem_req=1, mem_we=is_store, mem_addr=in_alu_rd_result[ADDR_WIDTH-1:0], mem_wdata=in_store_data, counter=0, wb_reg_wren=0.
- ACCESS: stall=1; mem_req and all request fields stay stable.
  - mem_ready=1: next edge mem_req=0, state→FINISH. For a load: wb_data=mem_rdata, wb_rd_address=in_rd_address, wb_reg_wren=in_reg_wren. For a store: wb_reg_wren=0.
  - mem_ready=0: counter increments. When counter==TIMEOUT_CYCLES, next edge mem_req=0, mem_error=1, wb_reg_wren=0, state→FINISH.
- FINISH: stall=0 for one cycle so EX/MEM advances. wb_* holds its captured values for this cycle. Next edge state→IDLE and wb_reg_wren=0; the instruction is never written back twice.
- Minimum latency: 0 extra cycles for non-memory instructions. Memory access with mem_ready at the first ACCESS cycle takes 2 stall cycles.
- mem_ready outside ACCESS is ignored.
- Redirect is combinational from in_next_pc_src and is gated so it asserts once per instruction: only when state==IDLE with no access, or state==FINISH.
  - 0: redirect=0, redirect_pc=in_pc_data+4 (mod 2^32).
  - 1: redirect=in_alu_rd_result_is_zero, redirect_pc=in_alu_pc_result if taken, else in_pc_data+4.
  - 2: redirect=1, redirect_pc=in_alu_pc_result.
  - 3: redirect=1, redirect_pc=in_alu_rd_result with bit0 cleared.
- in_pc_data=32'hFFFFFFFC with src 0 gives redirect_pc=0 (wrap-around).
- mem_error is cleared only by reset.
- Reset mid-ACCESS: mem_req drops immediately (async); no writeback occurs.

Test Plan:
- ALU op: in_reg_wren=1, rd=5, alu=32'h1234, no ram -> next cycle wb_rd_address=5, wb_data=32'h1234, wb_reg_wren=1, stall never 1.
- Load with 3-cycle latency: addr 32'h100, mem_ready on 3rd ACCESS cycle with rdata=32'hDEADBEEF -> mem_req high 3 cycles, stall high 4 cycles, then wb_data=32'hDEADBEEF and wb_reg_wren=1 for exactly 1 cycle.
- Store: ram_wren=1, addr 32'h200, store_data=32'hA5A5A5A5, immediate ready -> mem_we=1, mem_wdata=32'hA5A5A5A5, wb_reg_wren stays 0.
- Branch: src=1, is_zero=1, pc=32'h40, target=32'h80 -> redirect=1, redirect_pc=32'h80; is_zero=0 -> redirect=0, redirect_pc=32'h44.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req drops after 5 ACCESS cycles, mem_error=1 and sticky, wb_reg_wren=0.
- Reset mid-ACCESS: reset_n=0 asynchronously between edges -> mem_req=0, stall=0, state=IDLE immediately; late mem_ready is ignored.

Source files
------------

// File: rtl/mem_stage_access_unit_if.sv
// rtl/mem_stage_access_unit_if.sv - data-RAM request/ready bus between MEM stage and memory
//
// Purpose: groups the variable-latency data-RAM handshake into one bundle.
// Signals:
//   mem_req    master->slave  access request, held until mem_ready
//   mem_we     master->slave  1 = write, 0 = read
//   mem_addr   master->slave  access address (ADDR_WIDTH bits)
//   mem_wdata  master->slave  store data
//   mem_ready  slave->master  completion; mem_rdata valid in the same cycle
//   mem_rdata  slave->master  load data
interface mem_stage_access_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_stage_access_unit.sv
// rtl/mem_stage_access_unit.sv - MEM pipeline stage: data-RAM access, stall, writeback, next-PC
//
// Purpose: consumes the EX/MEM register fields, performs loads/stores over a
// variable-latency req/ready bus, stalls the front of the pipeline while an
// access is outstanding, and produces the MEM/WB bundle plus the PC redirect.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_*                    EX/MEM register fields (held stable while stall=1)
//   mem                     data-RAM bus (master side)
//   stall                   hold IF/ID/EX and EX/MEM
//   redirect, redirect_pc   PC load request and resolved next PC
//   wb_rd_address, wb_data, wb_reg_wren   MEM/WB register
//   mem_error               sticky access-timeout flag
module mem_stage_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_pc_data,
  input  logic [4:0]  in_rd_address,
  input  logic [31:0] in_alu_rd_result,
  input  logic        in_alu_rd_result_is_zero,
  input  logic [31:0] in_alu_pc_result,
  input  logic [1:0]  in_next_pc_src,
  input  logic        in_reg_write_data_src,
  input  logic        in_reg_wren,
  input  logic        in_ram_wren,
  input  logic [31:0] in_store_data,
  mem_stage_access_unit_if.master mem,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [4:0]  wb_rd_address,
  output logic [31:0] wb_data,
  output logic        wb_reg_wren,
  output logic        mem_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 stall_raw;
  logic                 redirect_en;
  logic                 redirect_take;
  logic                 timeout_hit;
  logic                 is_store, is_load, is_access;
  logic [31:0]          pc_plus4;

  // A store wins over a load when both flags are set.
  assign is_store    = in_ram_wren;
  assign is_load     = in_reg_write_data_src & ~in_ram_wren;
  assign is_access   = is_store | is_load;
  assign timeout_hit = (wait_cnt == TIMEOUT_VAL);
  assign pc_plus4    = in_pc_data + 32'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Redirect is only allowed in the one cycle where the instruction leaves
  // MEM, so a multi-cycle access cannot redirect the PC more than once.
  always_comb begin
    state_next  = state;
    stall_raw   = 1'b0;
    redirect_en = 1'b0;
    case (state)
      IDLE: begin
        if (is_access) begin
          stall_raw  = 1'b1;
          state_next = ACCESS;
        end else begin
          redirect_en = 1'b1;
        end
      end
      ACCESS: begin
        stall_raw = 1'b1;
        if (mem.mem_ready || timeout_hit) state_next = FINISH;
      end
      FINISH: begin
        redirect_en = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    redirect_take = 1'b0;
    redirect_pc   = pc_plus4;
    case (in_next_pc_src)
      2'd0: begin
        redirect_take = 1'b0;
        redirect_pc   = pc_plus4;
      end
      2'd1: begin
        redirect_take = in_alu_rd_result_is_zero;
        redirect_pc   = in_alu_rd_result_is_zero ? in_alu_pc_result : pc_plus4;
      end
      2'd2: begin
        redirect_take = 1'b1;
        redirect_pc   = in_alu_pc_result;
      end
      default: begin
        redirect_take = 1'b1;
        redirect_pc   = {in_alu_rd_result[31:1], 1'b0};
      end
    endcase
  end

  // The pipeline controls must read inactive for the whole time reset is held,
  // even though the EX/MEM fields feeding them may still show an access.
  assign stall    = reset_n & stall_raw;
  assign redirect = reset_n & redirect_en & redirect_take;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      wait_cnt      <= '0;
      wb_rd_address <= '0;
      wb_data       <= '0;
      wb_reg_wren   <= 1'b0;
      mem_error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_access) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store;
            mem.mem_addr  <= in_alu_rd_result[ADDR_WIDTH-1:0];
            mem.mem_wdata <= in_store_data;
            wait_cnt      <= '0;
            wb_reg_wren   <= 1'b0;
          end else begin
            wb_rd_address <= in_rd_address;
            wb_data       <= in_alu_rd_result;
            wb_reg_wren   <= in_reg_wren;
          end
        end
        ACCESS: begin
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            if (is_load) begin
              wb_rd_address <= in_rd_address;
              wb_data       <= mem.mem_rdata;
              wb_reg_wren   <= in_reg_wren;
            end else begin
              wb_reg_wren <= 1'b0;
            end
          end else if (timeout_hit) begin
            mem.mem_req <= 1'b0;
            mem_error   <= 1'b1;
            wb_reg_wren <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FINISH: begin
          // Clear so the captured result is written back exactly once.
          wb_reg_wren <= 1'b0;
        end
        default: begin
          wb_reg_wren <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// tb/tb_mem_stage_access_unit.sv - self-checking bench for mem_stage_access_unit
module tb_mem_stage_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_pc_data;
  logic [4:0]  in_rd_address;
  logic [31:0] in_alu_rd_result;
  logic        in_alu_rd_result_is_zero;
  logic [31:0] in_alu_pc_result;
  logic [1:0]  in_next_pc_src;
  logic        in_reg_write_data_src;
  logic        in_reg_wren;
  logic        in_ram_wren;
  logic [31:0] in_store_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [4:0]  wb_rd_address;
  logic [31:0] wb_data;
  logic        wb_reg_wren;
  logic        mem_error;

  mem_stage_access_unit_if #(.ADDR_WIDTH(32)) bus ();

  mem_stage_access_unit #(
    .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_pc_data(in_pc_data), .in_rd_address(in_rd_address),
    .in_alu_rd_result(in_alu_rd_result),
    .in_alu_rd_result_is_zero(in_alu_rd_result_is_zero),
    .in_alu_pc_result(in_alu_pc_result), .in_next_pc_src(in_next_pc_src),
    .in_reg_write_data_src(in_reg_write_data_src), .in_reg_wren(in_reg_wren),
    .in_ram_wren(in_ram_wren), .in_store_data(in_store_data),
    .mem(bus.master),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .wb_rd_address(wb_rd_address), .wb_data(wb_data),
    .wb_reg_wren(wb_reg_wren), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected contents of the MEM/WB register and the sticky error flag.
  logic        exp_wren = 1'b0;
  logic [4:0]  exp_rd   = '0;
  logic [31:0] exp_data = '0;
  logic        exp_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_next_pc(input logic [1:0] src, input logic z,
                                      input logic [31:0] pc, input logic [31:0] apc,
                                      input logic [31:0] ard,
                                      output logic r, output logic [31:0] npc);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (src == 2'd0)      begin r = 1'b0; npc = seq; end
    else if (src == 2'd1) begin r = z;    npc = z ? apc : seq; end
    else if (src == 2'd2) begin r = 1'b1; npc = apc; end
    else                  begin r = 1'b1; npc = ard & 32'hFFFF_FFFE; end
  endfunction

  // Presents one instruction at MEM and follows it until it leaves.
  // lat = ACCESS cycle on which memory answers; lat > TO+1 means it never does.
  task automatic do_instr(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] alu,
                          input logic z, input logic [31:0] apc, input logic [1:0] src,
                          input logic wds, input logic rw, input logic ramw,
                          input logic [31:0] sd, input int lat, input logic [31:0] rdv);
    logic        is_mem, is_ld, r;
    logic [31:0] npc;
    bit          timed_out;
    int          n;
    is_ld  = wds & ~ramw;
    is_mem = ramw | is_ld;
    ref_next_pc(src, z, pc, apc, alu, r, npc);
    in_pc_data = pc; in_rd_address = rd; in_alu_rd_result = alu;
    in_alu_rd_result_is_zero = z; in_alu_pc_result = apc; in_next_pc_src = src;
    in_reg_write_data_src = wds; in_reg_wren = rw; in_ram_wren = ramw; in_store_data = sd;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    @(negedge clk);
    check_eq("stall_first", stall, is_mem);
    check_eq("redirect_first", redirect, is_mem ? 1'b0 : r);
    if (!is_mem) check_eq("redirect_pc_first", redirect_pc, npc);
    check_eq("wb_wren_prev", wb_reg_wren, exp_wren);
    check_eq("mem_req_first", bus.mem_req, 1'b0);
    check_eq("mem_error", mem_error, exp_err);
    @(posedge clk); #1;
    if (!is_mem) begin
      exp_wren = rw; exp_rd = rd; exp_data = alu;
      check_eq("wb_wren_pass", wb_reg_wren, exp_wren);
      check_eq("wb_rd_pass", wb_rd_address, exp_rd);
      check_eq("wb_data_pass", wb_data, exp_data);
    end else begin
      exp_wren  = 1'b0;
      timed_out = (lat > TO + 1);
      n = timed_out ? TO + 1 : lat;
      for (int k = 1; k <= n; k++) begin
        bus.mem_ready = (k == lat);
        bus.mem_rdata = (k == lat) ? rdv : $urandom;
        @(negedge clk);
        check_eq("acc_mem_req", bus.mem_req, 1'b1);
        check_eq("acc_mem_we", bus.mem_we, ramw);
        check_eq("acc_mem_addr", bus.mem_addr, alu);
        check_eq("acc_mem_wdata", bus.mem_wdata, sd);
        check_eq("acc_stall", stall, 1'b1);
        check_eq("acc_redirect", redirect, 1'b0);
        check_eq("acc_wb_wren", wb_reg_wren, 1'b0);
        @(posedge clk); #1;
      end
      if (timed_out) exp_err = 1'b1;
      else if (is_ld) begin exp_wren = rw; exp_rd = rd; exp_data = rdv; end
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      @(negedge clk);
      check_eq("fin_mem_req", bus.mem_req, 1'b0);
      check_eq("fin_stall", stall, 1'b0);
      check_eq("fin_redirect", redirect, r);
      check_eq("fin_redirect_pc", redirect_pc, npc);
      check_eq("fin_wb_wren", wb_reg_wren, exp_wren);
      if (exp_wren) begin
        check_eq("fin_wb_rd", wb_rd_address, exp_rd);
        check_eq("fin_wb_data", wb_data, exp_data);
      end
      check_eq("fin_mem_error", mem_error, exp_err);
      @(posedge clk); #1;
      exp_wren = 1'b0;
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    in_pc_data = '0; in_rd_address = '0; in_alu_rd_result = '0;
    in_alu_rd_result_is_zero = 1'b0; in_alu_pc_result = '0; in_next_pc_src = '0;
    in_reg_write_data_src = 1'b0; in_reg_wren = 1'b0; in_ram_wren = 1'b0;
    in_store_data = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    #12;
    check_eq("rst_mem_req", bus.mem_req, 1'b0);
    check_eq("rst_mem_we", bus.mem_we, 1'b0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_wb_wren", wb_reg_wren, 1'b0);
    check_eq("rst_wb_data", wb_data, 32'h0);
    check_eq("rst_mem_error", mem_error, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_redirect", redirect, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // ALU op, load with 3-cycle latency, store with immediate ready
    do_instr(32'h10, 5'd5, 32'h1234, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1, 32'h0);
    do_instr(32'h14, 5'd6, 32'h100, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0, 3, 32'hDEADBEEF);
    do_instr(32'h18, 5'd7, 32'h200, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 1, 32'h0);
    // store and load flags together: treated as a store
    do_instr(32'h1C, 5'd8, 32'h204, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h5A5A5A5A, 2, 32'h1111);
    // branch taken / not taken, jumps, PC wrap
    do_instr(32'h40, 5'd0, 32'h0, 1'b1, 32'h80, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0, 1, 32'h0);
    do_instr(32'h40, 5'd0, 32'h0, 1'b0, 32'h80, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0, 1, 32'h0);
    do_instr(32'h50, 5'd1, 32'h0, 1'b0, 32'h900, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1, 32'h0);
    do_instr(32'h54, 5'd1, 32'h333, 1'b0, 32'h0, 2'd3, 1'b0, 1'b1, 1'b0, 32'h0, 1, 32'h0);
    do_instr(32'hFFFFFFFC, 5'd2, 32'h7, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1, 32'h0);
    // timeout on a load, then make sure the flag stays set
    do_instr(32'h60, 5'd9, 32'h300, 1'b0, 32'h0, 2'd2, 1'b1, 1'b1, 1'b0, 32'h0, 20, 32'hBAD);
    do_instr(32'h64, 5'd3, 32'h42, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFF_FFFC);
      do_instr(pc, 5'($urandom), $urandom, 1'($urandom_range(0, 1)), $urandom,
               2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom,
               $urandom_range(1, 7), $urandom);
    end

    // Asynchronous reset in the middle of an outstanding load
    in_reg_write_data_src = 1'b1; in_ram_wren = 1'b0; in_reg_wren = 1'b1;
    in_rd_address = 5'd12; in_alu_rd_result = 32'h400; in_next_pc_src = 2'd2;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check_eq("pre_rst_mem_req", bus.mem_req, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_mem_req", bus.mem_req, 1'b0);
    check_eq("midrst_stall", stall, 1'b0);
    check_eq("midrst_redirect", redirect, 1'b0);
    check_eq("midrst_wb_wren", wb_reg_wren, 1'b0);
    check_eq("midrst_mem_error", mem_error, 1'b0);
    exp_err = 1'b0;
    in_reg_write_data_src = 1'b0; in_reg_wren = 1'b0; in_next_pc_src = 2'd0;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_eq("late_ready_wb_wren", wb_reg_wren, 1'b0);
    check_eq("late_ready_mem_req", bus.mem_req, 1'b0);
    @(negedge clk);
    check_eq("late_ready_stall", stall, 1'b0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    exp_wren = 1'b0;
    do_instr(32'h70, 5'd4, 32'h99, 1'b0, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1, 32'h0);
    do_instr(32'h74, 5'd10, 32'h500, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0, 1, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
